// File: rtl/exibidor_pkg.sv
// Shared definitions for the sequence playback controller: state codes,
// default timing values and a small helper for sizing the cycle counter.
package exibidor_pkg;

    // State codes, also exported on db_estado
    localparam logic [2:0] ST_OCIOSO  = 3'd0;
    localparam logic [2:0] ST_PAUSA   = 3'd1;
    localparam logic [2:0] ST_LE      = 3'd2;
    localparam logic [2:0] ST_ACESO   = 3'd3;
    localparam logic [2:0] ST_APAGADO = 3'd4;
    localparam logic [2:0] ST_FIM     = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO  = ST_OCIOSO,
        PAUSA   = ST_PAUSA,
        LE      = ST_LE,
        ACESO   = ST_ACESO,
        APAGADO = ST_APAGADO,
        FIM     = ST_FIM
    } estado_t;

    // Default timings in clock cycles
    localparam int EXIBIDOR_T_PAUSA_PAD = 250;
    localparam int EXIBIDOR_T_ON_PAD    = 500;
    localparam int EXIBIDOR_T_OFF_PAD   = 250;

    // Largest of three durations, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/exibidor_sequencia_temporizador.sv
// Loadable down-counter with terminal-count flag, shared by the pause,
// lit and dark phases of the playback controller.
module temporizador_exibicao #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_carregar,
    input  logic [W-1:0] i_valor,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_carregar) begin
            r_cnt <= i_valor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence playback controller: walks ROM addresses 0..limite, lighting
// each pattern for a fixed on-time with dark gaps, then pulses fim.
// Optional macro EXIBIDOR_ACELERA_EN halves the on-time when lim >= 8.
module exibidor_sequencia
    import exibidor_pkg::*;
#(
    parameter int T_PAUSA = EXIBIDOR_T_PAUSA_PAD,
    parameter int T_ON    = EXIBIDOR_T_ON_PAD,
    parameter int T_OFF   = EXIBIDOR_T_OFF_PAD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] limite,
    output logic [3:0] rom_endereco,
    input  logic [6:0] rom_dado,
    output logic [6:0] leds,
    output logic       ocupado,
    output logic       fim,
    output logic [2:0] db_estado
);

    localparam int T_MAX = max3(T_PAUSA, T_ON, T_OFF);
    localparam int CW    = $clog2(T_MAX + 1);

    estado_t       r_estado, w_estado_next;
    logic [3:0]    r_idx, w_idx_next;
    logic [3:0]    r_lim, w_lim_next;
    logic [6:0]    r_leds, w_leds_next;
    logic          w_carregar;
    logic [CW-1:0] w_valor;
    logic [CW-1:0] w_t_ef;
    logic          w_tc;

`ifdef EXIBIDOR_ACELERA_EN
    // Long rounds flash faster
    assign w_t_ef = (r_lim >= 4'd8) ? CW'(T_ON / 2) : CW'(T_ON);
`else
    assign w_t_ef = CW'(T_ON);
`endif

    temporizador_exibicao #(
        .W (CW)
    ) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .i_carregar (w_carregar),
        .i_valor    (w_valor),
        .o_tc       (w_tc)
    );

    // State, index, limit and LED registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_idx    <= 4'd0;
            r_lim    <= 4'd0;
            r_leds   <= 7'd0;
        end else begin
            r_estado <= w_estado_next;
            r_idx    <= w_idx_next;
            r_lim    <= w_lim_next;
            r_leds   <= w_leds_next;
        end
    end

    // Next-state, timer loading and LED update; abort overrides everything
    always_comb begin
        w_estado_next = r_estado;
        w_idx_next    = r_idx;
        w_lim_next    = r_lim;
        w_leds_next   = r_leds;
        w_carregar    = 1'b0;
        w_valor       = '0;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_estado_next = PAUSA;
                    w_idx_next    = 4'd0;
                    w_lim_next    = limite;
                    w_carregar    = 1'b1;
                    w_valor       = CW'(T_PAUSA - 1);
                end
            end
            PAUSA: begin
                w_leds_next = 7'd0;
                if (w_tc) w_estado_next = LE;
            end
            LE: begin
                // Address has been stable for at least one cycle, data valid
                w_leds_next   = rom_dado;
                w_estado_next = ACESO;
                w_carregar    = 1'b1;
                w_valor       = w_t_ef - CW'(1);
            end
            ACESO: begin
                if (w_tc) begin
                    w_leds_next = 7'd0;
                    if (r_idx == r_lim) begin
                        w_estado_next = FIM;
                    end else begin
                        w_idx_next    = r_idx + 4'd1;
                        w_estado_next = APAGADO;
                        w_carregar    = 1'b1;
                        w_valor       = CW'(T_OFF - 1);
                    end
                end
            end
            APAGADO: begin
                w_leds_next = 7'd0;
                if (w_tc) w_estado_next = LE;
            end
            FIM: begin
                w_estado_next = OCIOSO;
            end
            default: begin
                w_estado_next = OCIOSO;
            end
        endcase
        if (abortar) begin
            w_estado_next = OCIOSO;
            w_leds_next   = 7'd0;
            w_idx_next    = 4'd0;
            w_carregar    = 1'b0;
        end
    end

    assign rom_endereco = r_idx;
    assign leds         = r_leds;
    assign ocupado      = (r_estado == PAUSA) || (r_estado == LE) ||
                          (r_estado == ACESO) || (r_estado == APAGADO);
    assign fim          = (r_estado == FIM);
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Randomized self-checking bench for exibidor_sequencia. Expected outputs
// come from a cycle-index arithmetic model of the playback schedule.
module tb_exibidor_sequencia;

    localparam int T_PAUSA = 3;
    localparam int T_ON    = 4;
    localparam int T_OFF   = 2;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] limite;
    logic [3:0] rom_endereco;
    logic [6:0] rom_dado;
    logic [6:0] leds;
    logic       ocupado;
    logic       fim;
    logic [2:0] db_estado;

    logic [6:0] rom [16];

    int n_checks = 0;
    int n_errors = 0;

    exibidor_sequencia #(
        .T_PAUSA (T_PAUSA),
        .T_ON    (T_ON),
        .T_OFF   (T_OFF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .abortar      (abortar),
        .limite       (limite),
        .rom_endereco (rom_endereco),
        .rom_dado     (rom_dado),
        .leds         (leds),
        .ocupado      (ocupado),
        .fim          (fim),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM, one cycle of read latency
    always @(posedge clock) rom_dado <= rom[rom_endereco];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int t_ef_of(input int lim);
`ifdef EXIBIDOR_ACELERA_EN
        return (lim >= 8) ? T_ON / 2 : T_ON;
`else
        return T_ON;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".leds"}, 32'(leds), 32'd0);
        chk({tag, ".ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, ".fim"}, 32'(fim), 32'd0);
        chk({tag, ".estado"}, 32'(db_estado), 32'd0);
        chk({tag, ".endereco"}, 32'(rom_endereco), 32'd0);
    endtask

    // One playback: start with limite=lim, optionally abort while the DUT
    // is in cycle abort_at, optionally jiggle iniciar/limite while busy.
    task automatic play(input int lim, input int abort_at, input bit noise);
        int tef, per, total, m, p, r;
        int e_st, e_leds, e_oc, e_fim;
        bit aborted;
        tef   = t_ef_of(lim);
        per   = 1 + tef + T_OFF;
        total = T_PAUSA + (lim + 1) * (1 + tef) + lim * T_OFF + 1;
        $display("play lim=%0d abort_at=%0d noise=%0d fim_cycle=%0d", lim, abort_at, noise, total);
        limite  = 4'(lim);
        iniciar = 1'b1;
        abortar = 1'b0;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int n = 1; n <= total + 2; n++) begin
            aborted = (n > abort_at);
            e_leds = 0; e_oc = 0; e_fim = 0; e_st = 0; p = -1;
            if (aborted || n > total) begin
                e_st = 0;
            end else if (n == total) begin
                e_st = 5; e_fim = 1;
            end else if (n <= T_PAUSA) begin
                e_st = 1; e_oc = 1;
            end else begin
                m = n - T_PAUSA - 1;
                p = m / per;
                r = m % per;
                e_oc = 1;
                if (r == 0) e_st = 2;
                else if (r <= tef) begin e_st = 3; e_leds = int'(rom[p]); end
                else e_st = 4;
            end
            chk("leds", 32'(leds), 32'(e_leds));
            chk("ocupado", 32'(ocupado), 32'(e_oc));
            chk("fim", 32'(fim), 32'(e_fim));
            chk("estado", 32'(db_estado), 32'(e_st));
            if (e_st == 2 || e_st == 3) chk("endereco", 32'(rom_endereco), 32'(p));
            if (e_st == 0) chk("endereco_ocioso", 32'(rom_endereco), 32'(aborted ? 0 : lim));
            // Drive inputs for the edge closing cycle n
            abortar = (n == abort_at);
            if (noise && e_st != 0 && e_st != 5) begin
                iniciar = 1'($urandom_range(0, 1));
                limite  = 4'($urandom_range(0, 15));
            end else begin
                iniciar = 1'b0;
            end
            @(posedge clock); #1;
        end
        abortar = 1'b0;
        iniciar = 1'b0;
    endtask

    initial begin
        int lim, tot, ab;
        for (int i = 0; i < 16; i++)
            rom[i] = (i < 7) ? 7'(1 << i) : 7'($urandom_range(1, 127));
        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; limite = 4'd0;
        @(posedge clock); #1;
        $display("reset check");
        chk_idle("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        play(0, 1000, 1'b0);
        play(2, 1000, 1'b0);
        // Abort in the first lit cycle of the second pattern, then restart
        play(2, T_PAUSA + 1 + (1 + T_ON + T_OFF) + 1, 1'b0);
        play(0, 1000, 1'b0);
        play(1, 1000, 1'b1);
        play(8, 1000, 1'b0);
        // Abort during the fim cycle of a lim=1 run
        play(1, T_PAUSA + 2 * (1 + T_ON) + T_OFF + 1, 1'b0);

        // Abort wins over a simultaneous start
        $display("abort with iniciar in idle");
        iniciar = 1'b1; abortar = 1'b1; limite = 4'd3;
        @(posedge clock); #1;
        iniciar = 1'b0; abortar = 1'b0;
        chk_idle("abort_vs_start");

        // Reset in mid-playback returns to idle
        $display("reset mid-playback");
        limite = 4'd4; iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        repeat (6) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_idle("reset_mid");

        for (int k = 0; k < 24; k++) begin
            lim = $urandom_range(0, 15);
            tot = T_PAUSA + (lim + 1) * (1 + t_ef_of(lim)) + lim * T_OFF + 1;
            ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, tot) : 1000;
            play(lim, ab, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
